// File: rtl/bird_flock_renderer.sv
// bird_flock_renderer
//   Multi-bird sprite engine for the 160x120 duck-hunt playfield. Each frame
//   tick runs a fixed sequence: erase every live bird, one bookkeeping cycle
//   (kill / advance / escape / spawn), then redraw. One pixel per cycle goes
//   straight to vga_adapter.
//
// Ports
//   clock       system clock (CLOCK_50)
//   resetn      synchronous active-low reset
//   frame_tick  one-cycle frame pulse; only honoured while idle
//   spawn_en    allow one spawn in this frame's update cycle
//   spawn_y     spawn row (clamped to 3..116 so the wing stays on screen)
//   kill_valid  one-cycle kill request for slot kill_idx
//   kill_idx    slot to kill
//   x, y        pixel coordinate (held when nothing is plotted)
//   colour      pixel colour
//   plot        pixel write strobe
//   busy        high while a frame sequence runs
//   frame_done  one-cycle pulse in the first idle cycle after a sequence
//   active      per-slot alive flags
//   escaped     one-cycle pulse: at least one bird left the right edge
//   hit         one-cycle pulse: at least one kill was applied
module bird_flock_renderer #(
  parameter int          NUM_BIRDS   = 4,
  parameter int          IDX_W       = 2,
  parameter int          SPEED       = 1,
  parameter logic [2:0]  BIRD_COLOUR = 3'b110,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 frame_tick,
  input  logic                 spawn_en,
  input  logic [6:0]           spawn_y,
  input  logic                 kill_valid,
  input  logic [IDX_W-1:0]     kill_idx,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic                 plot,
  output logic                 busy,
  output logic                 frame_done,
  output logic [NUM_BIRDS-1:0] active,
  output logic                 escaped,
  output logic                 hit
);

  typedef enum logic [1:0] {IDLE, ERASE, UPDATE, DRAW} state_t;

  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_BIRDS - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] slot_reg, slot_next;
  logic [3:0]       pix_reg, pix_next;
  logic             in_update;

  // Per-slot values as they will be after this clock edge. The pixel path
  // reads these so the first DRAW pixel already sees the updated bird.
  logic [7:0]           slot_x_next [NUM_BIRDS];
  logic [6:0]           slot_y_next [NUM_BIRDS];
  logic [NUM_BIRDS-1:0] slot_phase_next;
  logic [NUM_BIRDS-1:0] slot_act_next;
  logic [NUM_BIRDS-1:0] act_vec;
  logic [NUM_BIRDS-1:0] kill_apply;
  logic [NUM_BIRDS-1:0] escape_vec;
  logic [NUM_BIRDS-1:0] spawn_sel;
  logic                 spawn_found;
  logic [6:0]           spawn_y_clamped;

  assign in_update = (state_reg == UPDATE);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg <= IDLE;
      slot_reg  <= '0;
      pix_reg   <= '0;
    end else begin
      state_reg <= state_next;
      slot_reg  <= slot_next;
      pix_reg   <= pix_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    slot_next  = slot_reg;
    pix_next   = pix_reg;
    unique case (state_reg)
      IDLE: begin
        if (frame_tick) begin
          state_next = ERASE;
          slot_next  = '0;
          pix_next   = '0;
        end
      end
      ERASE, DRAW: begin
        if (pix_reg == 4'd9) begin
          pix_next = '0;
          if (slot_reg == LAST_SLOT) begin
            state_next = (state_reg == ERASE) ? UPDATE : IDLE;
            slot_next  = '0;
          end else begin
            slot_next = slot_reg + 1'b1;
          end
        end else begin
          pix_next = pix_reg + 4'd1;
        end
      end
      UPDATE: begin
        state_next = DRAW;
        slot_next  = '0;
        pix_next   = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------- spawn selection ----------------
  assign spawn_y_clamped = (spawn_y < 7'd3)   ? 7'd3   :
                           (spawn_y > 7'd116) ? 7'd116 : spawn_y;

  // Lowest slot that is free at the start of UPDATE; slots freed during this
  // same UPDATE still read as active here, so they wait a frame.
  always_comb begin
    spawn_sel   = '0;
    spawn_found = 1'b0;
    if (in_update && spawn_en) begin
      for (int i = 0; i < NUM_BIRDS; i++) begin
        if (!spawn_found && !act_vec[i]) begin
          spawn_sel[i] = 1'b1;
          spawn_found  = 1'b1;
        end
      end
    end
  end

  // ---------------- bird slots ----------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BIRDS; gi++) begin : g_slot
      logic [7:0] x_reg, x_next;
      logic [6:0] y_reg, y_next;
      logic       phase_reg, phase_next;
      logic       act_reg, act_next;
      logic       kill_pend_reg, kill_pend_next;
      logic [8:0] adv_x;
      logic       kill_req, kill_now, esc_now;

      assign adv_x    = {1'b0, x_reg} + 9'(SPEED);
      // Out-of-range indices match no slot; dead slots ignore kills.
      assign kill_req = kill_valid && (kill_idx == IDX_W'(gi)) && act_reg;
      assign kill_now = in_update && act_reg && kill_pend_reg;
      assign esc_now  = in_update && act_reg && !kill_pend_reg && (adv_x >= 9'd165);

      always_comb begin
        x_next     = x_reg;
        y_next     = y_reg;
        phase_next = phase_reg;
        act_next   = act_reg;
        // UPDATE consumes all pending kills; a request landing in that very
        // cycle survives into the next frame.
        kill_pend_next = (kill_pend_reg && !in_update) || kill_req;
        if (kill_now) begin
          act_next = 1'b0;
        end else if (in_update && act_reg) begin
          x_next     = adv_x[7:0];
          phase_next = ~phase_reg;
          if (esc_now) act_next = 1'b0;
        end else if (spawn_sel[gi]) begin
          act_next   = 1'b1;
          x_next     = '0;
          phase_next = 1'b0;
          y_next     = spawn_y_clamped;
        end
      end

      always_ff @(posedge clock) begin
        if (!resetn) begin
          x_reg         <= '0;
          y_reg         <= '0;
          phase_reg     <= 1'b0;
          act_reg       <= 1'b0;
          kill_pend_reg <= 1'b0;
        end else begin
          x_reg         <= x_next;
          y_reg         <= y_next;
          phase_reg     <= phase_next;
          act_reg       <= act_next;
          kill_pend_reg <= kill_pend_next;
        end
      end

      assign slot_x_next[gi]     = x_next;
      assign slot_y_next[gi]     = y_next;
      assign slot_phase_next[gi] = phase_next;
      assign slot_act_next[gi]   = act_next;
      assign act_vec[gi]         = act_reg;
      assign kill_apply[gi]      = kill_now;
      assign escape_vec[gi]      = esc_now;
    end
  endgenerate

  // ---------------- FSM: outputs (pixel for the step being entered) ----------------
  logic [7:0]        sel_x;
  logic [6:0]        sel_y;
  logic              sel_phase, sel_act;
  logic signed [8:0] wing, dx, dy, px_calc, py_calc;
  logic              plot_next;
  logic [2:0]        colour_next;

  always_comb begin
    sel_x     = slot_x_next[slot_next];
    sel_y     = slot_y_next[slot_next];
    sel_phase = slot_phase_next[slot_next];
    sel_act   = slot_act_next[slot_next];
    wing      = sel_phase ? -9'sd1 : 9'sd1;
    dx        = 9'sd0;
    dy        = 9'sd0;
    case (pix_next)
      4'd1:    dy = 9'sd1;
      4'd2:    dx = -9'sd1;
      4'd3:    dx = -9'sd2;
      4'd4:    dx = -9'sd3;
      4'd5:    dx = -9'sd4;
      4'd6:    dx = -9'sd5;
      4'd7:    begin dx = -9'sd3; dy = wing;                  end
      4'd8:    begin dx = -9'sd4; dy = wing <<< 1;            end
      4'd9:    begin dx = -9'sd5; dy = wing + (wing <<< 1);   end
      default: begin dx = 9'sd0;  dy = 9'sd0;                 end
    endcase
    px_calc     = $signed({1'b0, sel_x}) + dx;
    py_calc     = $signed({2'b0, sel_y}) + dy;
    plot_next   = ((state_next == ERASE) || (state_next == DRAW)) && sel_act &&
                  (px_calc >= 9'sd0) && (px_calc <= 9'sd159) &&
                  (py_calc >= 9'sd0) && (py_calc <= 9'sd119);
    colour_next = (state_next == DRAW) ? BIRD_COLOUR : BG_COLOUR;
  end

  logic [7:0] x_reg;
  logic [6:0] y_reg;
  logic [2:0] colour_reg;
  logic       plot_reg, busy_reg, frame_done_reg, escaped_reg, hit_reg;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      x_reg          <= '0;
      y_reg          <= '0;
      colour_reg     <= '0;
      plot_reg       <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
      escaped_reg    <= 1'b0;
      hit_reg        <= 1'b0;
    end else begin
      plot_reg <= plot_next;
      if (plot_next) begin
        x_reg      <= px_calc[7:0];
        y_reg      <= py_calc[6:0];
        colour_reg <= colour_next;
      end
      busy_reg       <= (state_next != IDLE);
      frame_done_reg <= (state_reg == DRAW) && (state_next == IDLE);
      escaped_reg    <= |escape_vec;
      hit_reg        <= |kill_apply;
    end
  end

  assign x          = x_reg;
  assign y          = y_reg;
  assign colour     = colour_reg;
  assign plot       = plot_reg;
  assign busy       = busy_reg;
  assign frame_done = frame_done_reg;
  assign escaped    = escaped_reg;
  assign hit        = hit_reg;
  assign active     = act_vec;

endmodule
